// File: rtl/trace_sync_ctrl_if.sv
// rtl/trace_sync_ctrl_if.sv - trace sync controller bus bundle
//
// Purpose: groups the controller's configuration, capture-datapath
// handshake and status signals into one bundle.
//   master : drives enable/cfgAuto/cfgWidth/syncSeen/PkAvail/clearCount,
//            observes width/ifRst/locked/lostSync/state/frameCount.
//   slave  : the controller side (trace_sync_ctrl).
interface trace_sync_ctrl_if;
   logic        enable;
   logic        cfgAuto;
   logic [1:0]  cfgWidth;
   logic        syncSeen;
   logic        PkAvail;
   logic        clearCount;
   logic [1:0]  width;
   logic        ifRst;
   logic        locked;
   logic        lostSync;
   logic [2:0]  state;
   logic [15:0] frameCount;

   modport master (
      output enable, cfgAuto, cfgWidth, syncSeen, PkAvail, clearCount,
      input  width, ifRst, locked, lostSync, state, frameCount
   );

   modport slave (
      input  enable, cfgAuto, cfgWidth, syncSeen, PkAvail, clearCount,
      output width, ifRst, locked, lostSync, state, frameCount
   );
endinterface

// File: rtl/trace_sync_ctrl.sv
// rtl/trace_sync_ctrl.sv - trace port width hunt and sync lock controller
//
// Purpose: selects the trace bus width, holds the capture datapath in reset
// after each (re)selection, hunts for sync pulses, declares lock, detects
// loss of lock and counts frames received while locked.
// Ports:
//   traceClkin : trace clock, all logic on its rising edge
//   rst        : asynchronous, active-high reset
//   trc_io     : slave side of trace_sync_ctrl_if
//                in : enable, cfgAuto, cfgWidth, syncSeen, PkAvail, clearCount
//                out: width, ifRst, locked, lostSync, state, frameCount
module trace_sync_ctrl #(
   parameter int HUNT_CYCLES  = 4096,
   parameter int LOSS_CYCLES  = 65536,
   parameter int CONFIRM      = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input logic                traceClkin,
   input logic                rst,
   trace_sync_ctrl_if.slave   trc_io
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FLUSH  = 3'd1,
      HUNT   = 3'd2,
      LOCKED = 3'd3
   } state_e;

   // One timer is shared by FLUSH, HUNT and LOCKED; size it for the longest.
   localparam int HUNT_W  = $clog2(HUNT_CYCLES);
   localparam int LOSS_W  = $clog2(LOSS_CYCLES);
   localparam int FLUSH_W = $clog2(FLUSH_CYCLES);
   localparam int MAX_HL  = (HUNT_W > LOSS_W) ? HUNT_W : LOSS_W;
   localparam int MAX_W   = (MAX_HL > FLUSH_W) ? MAX_HL : FLUSH_W;
   localparam int TMR_W   = (MAX_W < 1) ? 1 : MAX_W;
   localparam int CNT_W   = $clog2(CONFIRM + 1);

   state_e              state_q, state_d;
   logic [1:0]          width_q, width_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [CNT_W-1:0]    sync_cnt_q, sync_cnt_d;
   logic                lost_q, lost_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic                pk_prev_q;
   logic                cfg_auto_q;
   logic [1:0]          cfg_width_q;

   logic [1:0]          target_width;
   logic [1:0]          next_width;
   logic                cfg_change;
   logic [CNT_W-1:0]    sync_inc;

   assign target_width = trc_io.cfgAuto ? 2'd3 : trc_io.cfgWidth;
   assign cfg_change   = (trc_io.cfgAuto != cfg_auto_q) || (trc_io.cfgWidth != cfg_width_q);
   assign sync_inc     = sync_cnt_q + CNT_W'(trc_io.syncSeen);

   // Auto hunt order 3 -> 2 -> 1 -> 3; code 0 falls back to 3.
   always_comb begin
      case (width_q)
         2'd3:    next_width = 2'd2;
         2'd2:    next_width = 2'd1;
         default: next_width = 2'd3;
      endcase
   end

   always_ff @(posedge traceClkin or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         width_q     <= 2'd3;
         timer_q     <= '0;
         sync_cnt_q  <= '0;
         lost_q      <= 1'b0;
         frame_cnt_q <= '0;
         pk_prev_q   <= 1'b0;
         cfg_auto_q  <= 1'b0;
         cfg_width_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         timer_q     <= timer_d;
         sync_cnt_q  <= sync_cnt_d;
         lost_q      <= lost_d;
         frame_cnt_q <= frame_cnt_d;
         pk_prev_q   <= trc_io.PkAvail;
         cfg_auto_q  <= trc_io.cfgAuto;
         cfg_width_q <= trc_io.cfgWidth;
      end
   end

   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      timer_d    = timer_q;
      sync_cnt_d = sync_cnt_q;
      lost_d     = 1'b0;
      if (!trc_io.enable) begin
         state_d    = IDLE;
         timer_d    = '0;
         sync_cnt_d = '0;
      end else if (state_q != IDLE && cfg_change) begin
         // Reconfiguration is not a loss of lock, so no lostSync here.
         state_d    = FLUSH;
         width_d    = target_width;
         timer_d    = '0;
         sync_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FLUSH;
               width_d = target_width;
               timer_d = '0;
            end
            FLUSH: begin
               if (timer_q == TMR_W'(FLUSH_CYCLES - 1)) begin
                  state_d    = HUNT;
                  timer_d    = '0;
                  sync_cnt_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            HUNT: begin
               // The sync on the timeout cycle is counted before the timeout
               // is acted on, so a completed CONFIRM wins.
               if (sync_inc == CNT_W'(CONFIRM)) begin
                  state_d    = LOCKED;
                  timer_d    = '0;
                  sync_cnt_d = sync_inc;
               end else if (timer_q == TMR_W'(HUNT_CYCLES - 1)) begin
                  timer_d    = '0;
                  sync_cnt_d = '0;
                  if (trc_io.cfgAuto) begin
                     state_d = FLUSH;
                     width_d = next_width;
                  end
               end else begin
                  timer_d    = timer_q + TMR_W'(1);
                  sync_cnt_d = sync_inc;
               end
            end
            LOCKED: begin
               if (trc_io.syncSeen) begin
                  timer_d = '0;
               end else if (timer_q == TMR_W'(LOSS_CYCLES - 1)) begin
                  state_d = FLUSH;
                  timer_d = '0;
                  lost_d  = 1'b1;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (trc_io.clearCount) begin
         frame_cnt_d = '0;
      end else if (state_q == LOCKED && trc_io.PkAvail != pk_prev_q &&
                   frame_cnt_q != 16'hFFFF) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
   end

   assign trc_io.width      = width_q;
   assign trc_io.ifRst      = (state_q == IDLE) || (state_q == FLUSH);
   assign trc_io.locked     = (state_q == LOCKED);
   assign trc_io.lostSync   = lost_q;
   assign trc_io.state      = state_q;
   assign trc_io.frameCount = frame_cnt_q;

endmodule

// File: tb/tb_trace_sync_ctrl.sv
// tb/tb_trace_sync_ctrl.sv - directed self-checking bench for trace_sync_ctrl
module tb_trace_sync_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic rst_h;
   int   n_chk = 0;
   int   n_err = 0;

   trace_sync_ctrl_if m_if ();
   trace_sync_ctrl_if h_if ();

   trace_sync_ctrl #(.HUNT_CYCLES(128), .LOSS_CYCLES(32), .CONFIRM(2), .FLUSH_CYCLES(2)) dut (
      .traceClkin (clk),
      .rst        (rst),
      .trc_io     (m_if.slave)
   );

   trace_sync_ctrl #(.HUNT_CYCLES(16), .LOSS_CYCLES(32), .CONFIRM(2), .FLUSH_CYCLES(2)) dut_h (
      .traceClkin (clk),
      .rst        (rst_h),
      .trc_io     (h_if.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Checks state/width/ifRst/locked/lostSync of the main (hsel=0) or hunt DUT.
   task automatic chk_o(input string tag, input bit hsel, input logic [2:0] st,
                        input logic [1:0] w, input logic ir, input logic lk, input logic ls);
      if (!hsel) begin
         check($sformatf("%s.state", tag), 32'(m_if.state), 32'(st));
         check($sformatf("%s.width", tag), 32'(m_if.width), 32'(w));
         check($sformatf("%s.ifRst", tag), 32'(m_if.ifRst), 32'(ir));
         check($sformatf("%s.locked", tag), 32'(m_if.locked), 32'(lk));
         check($sformatf("%s.lostSync", tag), 32'(m_if.lostSync), 32'(ls));
      end else begin
         check($sformatf("%s.state", tag), 32'(h_if.state), 32'(st));
         check($sformatf("%s.width", tag), 32'(h_if.width), 32'(w));
         check($sformatf("%s.ifRst", tag), 32'(h_if.ifRst), 32'(ir));
         check($sformatf("%s.locked", tag), 32'(h_if.locked), 32'(lk));
         check($sformatf("%s.lostSync", tag), 32'(h_if.lostSync), 32'(ls));
      end
   endtask

   task automatic toggle_pk(input int n);
      repeat (n) begin
         m_if.PkAvail = ~m_if.PkAvail;
         tick(1);
      end
   endtask

   initial begin
      logic [1:0] hunt_seq [3];
      hunt_seq[0] = 2'd2;
      hunt_seq[1] = 2'd1;
      hunt_seq[2] = 2'd3;

      rst = 1'b1;
      rst_h = 1'b1;
      m_if.enable = 1'b0;  m_if.cfgAuto = 1'b1;  m_if.cfgWidth = 2'd0;
      m_if.syncSeen = 1'b0; m_if.PkAvail = 1'b0; m_if.clearCount = 1'b0;
      h_if.enable = 1'b0;  h_if.cfgAuto = 1'b1;  h_if.cfgWidth = 2'd0;
      h_if.syncSeen = 1'b0; h_if.PkAvail = 1'b0; h_if.clearCount = 1'b0;
      tick(2);
      chk_o("reset", 0, 3'd0, 2'd3, 1'b1, 1'b0, 1'b0);
      check("reset.frames", 32'(m_if.frameCount), 32'd0);

      // Auto lock at width 3 with two syncs 100 cycles apart.
      rst = 1'b0;
      tick(1);
      chk_o("idle", 0, 3'd0, 2'd3, 1'b1, 1'b0, 1'b0);
      m_if.enable = 1'b1;
      tick(1);
      chk_o("flush0", 0, 3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("flush1", 0, 3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("hunt", 0, 3'd2, 2'd3, 1'b0, 1'b0, 1'b0);
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      tick(99);
      chk_o("hunt.wait", 0, 3'd2, 2'd3, 1'b0, 1'b0, 1'b0);
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      chk_o("lock", 0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0);

      // Frame counting and clear priority.
      toggle_pk(5);
      check("frames.5", 32'(m_if.frameCount), 32'd5);
      m_if.clearCount = 1'b1;
      toggle_pk(1);
      m_if.clearCount = 1'b0;
      check("frames.clr", 32'(m_if.frameCount), 32'd0);
      toggle_pk(1);
      check("frames.resume", 32'(m_if.frameCount), 32'd1);

      // Sync on the expiry cycle rescues lock; then a real loss.
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      tick(31);
      chk_o("loss.pre", 0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0);
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      chk_o("loss.rescue", 0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0);
      tick(31);
      chk_o("loss.pre2", 0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0);
      tick(1);
      chk_o("loss", 0, 3'd1, 2'd3, 1'b1, 1'b0, 1'b1);
      tick(1);
      chk_o("loss.after", 0, 3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("relock.hunt", 0, 3'd2, 2'd3, 1'b0, 1'b0, 1'b0);

      // Second sync lands on the hunt timeout cycle: lock wins.
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      tick(126);
      m_if.syncSeen = 1'b1; tick(1); m_if.syncSeen = 1'b0;
      chk_o("hunt.edge", 0, 3'd3, 2'd3, 1'b0, 1'b1, 1'b0);

      // Fixed mode: switch to width 1, lock, then change to width 2.
      m_if.cfgAuto = 1'b0; m_if.cfgWidth = 2'd1;
      tick(1);
      chk_o("fix.flush", 0, 3'd1, 2'd1, 1'b1, 1'b0, 1'b0);
      tick(2);
      chk_o("fix.hunt", 0, 3'd2, 2'd1, 1'b0, 1'b0, 1'b0);
      m_if.syncSeen = 1'b1; tick(2); m_if.syncSeen = 1'b0;
      chk_o("fix.lock", 0, 3'd3, 2'd1, 1'b0, 1'b1, 1'b0);
      m_if.cfgWidth = 2'd2;
      tick(1);
      chk_o("cfg.change", 0, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("cfg.nolost", 0, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0);
      tick(1);
      check("cfg.hunt", 32'(m_if.state), 32'd2);

      // Disable wins over a simultaneous config change.
      m_if.enable = 1'b0; m_if.cfgWidth = 2'd3;
      tick(1);
      check("dis.state", 32'(m_if.state), 32'd0);
      check("dis.ifRst", 32'(m_if.ifRst), 32'd1);
      check("dis.locked", 32'(m_if.locked), 32'd0);
      m_if.cfgWidth = 2'd2; m_if.enable = 1'b1;
      tick(1);
      chk_o("reen", 0, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0);

      // Lock with frameCount=7, then async reset.
      m_if.clearCount = 1'b1; tick(1); m_if.clearCount = 1'b0;
      tick(1);
      m_if.syncSeen = 1'b1; tick(2); m_if.syncSeen = 1'b0;
      chk_o("lock2", 0, 3'd3, 2'd2, 1'b0, 1'b1, 1'b0);
      toggle_pk(7);
      check("frames.7", 32'(m_if.frameCount), 32'd7);
      rst = 1'b1;
      #1;
      chk_o("rst.async", 0, 3'd0, 2'd3, 1'b1, 1'b0, 1'b0);
      check("rst.frames", 32'(m_if.frameCount), 32'd0);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk_o("rst.resume", 0, 3'd1, 2'd2, 1'b1, 1'b0, 1'b0);

      // Auto hunt rotation on the short-window instance: 3 -> 2 -> 1 -> 3.
      rst_h = 1'b0;
      h_if.enable = 1'b1;
      tick(1);
      chk_o("h.flush0", 1, 3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("h.flush1", 1, 3'd1, 2'd3, 1'b1, 1'b0, 1'b0);
      tick(1);
      chk_o("h.hunt", 1, 3'd2, 2'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(15);
         chk_o($sformatf("h.end%0d", i), 1, 3'd2, (i == 0) ? 2'd3 : hunt_seq[i-1], 1'b0, 1'b0, 1'b0);
         tick(1);
         chk_o($sformatf("h.fl0_%0d", i), 1, 3'd1, hunt_seq[i], 1'b1, 1'b0, 1'b0);
         tick(1);
         chk_o($sformatf("h.fl1_%0d", i), 1, 3'd1, hunt_seq[i], 1'b1, 1'b0, 1'b0);
         tick(1);
         chk_o($sformatf("h.hunt%0d", i), 1, 3'd2, hunt_seq[i], 1'b0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
